// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipeline hazard controller
package pipe_pkg;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC  = 2'b10;

    localparam int DEF_MUL_CYCLES = 4;
    localparam int DEF_DIV_CYCLES = 33;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    typedef enum logic [2:0] {
        PRI_NONE  = 3'd0,
        PRI_MEM   = 3'd1,
        PRI_HAZ   = 3'd2,
        PRI_FLUSH = 3'd3,
        PRI_RESET = 3'd4
    } pri_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-side hazard inputs and stall/flush controls
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_rs_used_i;
    logic       id_rt_used_i;
    logic       id_hilo_rd_i;
    logic       id_md_op_i;
    logic       id_br_taken_i;
    logic [1:0] idex_MemtoReg_i;
    logic       idex_RegWr_i;
    logic [4:0] idex_RegDstAddr_i;
    logic       ex_md_start_i;
    logic       ex_md_is_div_i;
    logic       mem_stall_i;

    logic       pc_wr_en_o;
    logic       ifid_en_o;
    logic       ifid_flush_o;
    logic       idex_en_o;
    logic       idex_bubble_o;
    logic       exmem_en_o;
    logic       memwb_bubble_o;
    logic       md_busy_o;
    logic       md_done_o;

    modport master (
        output id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, id_hilo_rd_i,
               id_md_op_i, id_br_taken_i, idex_MemtoReg_i, idex_RegWr_i,
               idex_RegDstAddr_i, ex_md_start_i, ex_md_is_div_i, mem_stall_i,
        input  pc_wr_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_bubble_o,
               exmem_en_o, memwb_bubble_o, md_busy_o, md_done_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, id_hilo_rd_i,
               id_md_op_i, id_br_taken_i, idex_MemtoReg_i, idex_RegWr_i,
               idex_RegDstAddr_i, ex_md_start_i, ex_md_is_div_i, mem_stall_i,
        output pc_wr_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_bubble_o,
               exmem_en_o, memwb_bubble_o, md_busy_o, md_done_o
    );

endinterface

// File: rtl/md_busy_cnt.sv
// rtl/md_busy_cnt.sv - mult/div occupancy FSM and countdown of HI/LO latency
module md_busy_cnt
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    input  logic mem_stall,
    output logic md_busy,
    output logic md_done
);

    if (CNT_W < $clog2(DIV_CYCLES + 1) || MUL_CYCLES < 1) begin : g_bad_cfg
        $error("md_busy_cnt: CNT_W too narrow or latency out of range");
    end

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The countdown keeps running under a memory wait; only the launch is gated.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start && !mem_stall) begin
                    state_d = MD_BUSY;
                    cnt_d   = md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy = (state_q == MD_BUSY);
    assign md_done = (state_q == MD_BUSY) && (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer; PIPE_HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_mem_stall_o,
    output logic [PERF_W-1:0]  perf_hazard_stall_o,
    output logic [PERF_W-1:0]  perf_flush_o
`endif
);

    if (PERF_W < 1) begin : g_bad_perf
        $error("pipe_hazard_ctrl: PERF_W must be positive");
    end

    logic md_busy;
    logic md_done;
    logic load_use;
    logic md_hold;
    pri_e pri;

    md_busy_cnt #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_cnt (
        .clk       (clk),
        .reset     (reset),
        .md_start  (hz.ex_md_start_i),
        .md_is_div (hz.ex_md_is_div_i),
        .mem_stall (hz.mem_stall_i),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    assign load_use = (hz.idex_MemtoReg_i == MTR_MEM) && hz.idex_RegWr_i &&
                      (hz.idex_RegDstAddr_i != 5'd0) &&
                      ((hz.id_rs_used_i && (hz.id_rs_i == hz.idex_RegDstAddr_i)) ||
                       (hz.id_rt_used_i && (hz.id_rt_i == hz.idex_RegDstAddr_i)));

    assign md_hold = md_busy && (hz.id_hilo_rd_i || hz.id_md_op_i);

    // A taken branch only wins when nothing is stalling, so it is replayed after release.
    always_comb begin
        pri = PRI_NONE;
        if (!reset) begin
            pri = PRI_RESET;
        end else if (hz.mem_stall_i) begin
            pri = PRI_MEM;
        end else if (load_use || md_hold) begin
            pri = PRI_HAZ;
        end else if (hz.id_br_taken_i) begin
            pri = PRI_FLUSH;
        end
    end

    always_comb begin
        hz.pc_wr_en_o     = 1'b1;
        hz.ifid_en_o      = 1'b1;
        hz.ifid_flush_o   = 1'b0;
        hz.idex_en_o      = 1'b1;
        hz.idex_bubble_o  = 1'b0;
        hz.exmem_en_o     = 1'b1;
        hz.memwb_bubble_o = 1'b0;
        case (pri)
            PRI_RESET: begin
                hz.pc_wr_en_o     = 1'b0;
                hz.ifid_en_o      = 1'b0;
                hz.ifid_flush_o   = 1'b1;
                hz.idex_en_o      = 1'b0;
                hz.idex_bubble_o  = 1'b1;
                hz.exmem_en_o     = 1'b0;
                hz.memwb_bubble_o = 1'b1;
            end
            PRI_MEM: begin
                hz.pc_wr_en_o     = 1'b0;
                hz.ifid_en_o      = 1'b0;
                hz.idex_en_o      = 1'b0;
                hz.exmem_en_o     = 1'b0;
                hz.memwb_bubble_o = 1'b1;
            end
            PRI_HAZ: begin
                hz.pc_wr_en_o     = 1'b0;
                hz.ifid_en_o      = 1'b0;
                hz.idex_bubble_o  = 1'b1;
            end
            PRI_FLUSH: begin
                hz.ifid_flush_o   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign hz.md_busy_o = md_busy;
    assign hz.md_done_o = md_done;

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_mem_q, perf_mem_d;
    logic [PERF_W-1:0] perf_haz_q, perf_haz_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_mem_q   <= '0;
            perf_haz_q   <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_mem_q   <= perf_mem_d;
            perf_haz_q   <= perf_haz_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        perf_mem_d   = perf_mem_q;
        perf_haz_d   = perf_haz_q;
        perf_flush_d = perf_flush_q;
        if (pri == PRI_MEM && perf_mem_q != '1) begin
            perf_mem_d = perf_mem_q + PERF_W'(1);
        end
        if (pri == PRI_HAZ && perf_haz_q != '1) begin
            perf_haz_d = perf_haz_q + PERF_W'(1);
        end
        if (pri == PRI_FLUSH && perf_flush_q != '1) begin
            perf_flush_d = perf_flush_q + PERF_W'(1);
        end
    end

    assign perf_mem_stall_o    = perf_mem_q;
    assign perf_hazard_stall_o = perf_haz_q;
    assign perf_flush_o        = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with a cycle-level reference model
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_m, perf_h, perf_f;
`endif

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_mem_stall_o    (perf_m),
        .perf_hazard_stall_o (perf_h),
        .perf_flush_o        (perf_f)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_u;
        logic       rt_u;
        logic       hilo;
        logic       mdop;
        logic       br;
        logic [1:0] mtr;
        logic       rw;
        logic [4:0] dst;
        logic       start;
        logic       isdiv;
        logic       ms;
    } stim_t;

    typedef struct {
        logic [8:0]  ctl;
        int unsigned pm;
        int unsigned ph;
        int unsigned pf;
        string       tag;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int md_start_cyc = -1;
    int md_end_cyc = -1;
    int unsigned cnt_m = 0, cnt_h = 0, cnt_f = 0;

    function automatic stim_t nop();
        stim_t s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // Model: mult/div occupies cycles (start, start+N], HI/LO valid in the last one.
    task automatic step(input stim_t s, input string tag);
        exp_t e;
        logic busy, done, lu, hold;
        logic [6:0] o;
        @(posedge clk);
        #1;
        reset                = s.rst;
        hz.id_rs_i           = s.rs;
        hz.id_rt_i           = s.rt;
        hz.id_rs_used_i      = s.rs_u;
        hz.id_rt_used_i      = s.rt_u;
        hz.id_hilo_rd_i      = s.hilo;
        hz.id_md_op_i        = s.mdop;
        hz.id_br_taken_i     = s.br;
        hz.idex_MemtoReg_i   = s.mtr;
        hz.idex_RegWr_i      = s.rw;
        hz.idex_RegDstAddr_i = s.dst;
        hz.ex_md_start_i     = s.start;
        hz.ex_md_is_div_i    = s.isdiv;
        hz.mem_stall_i       = s.ms;

        busy = s.rst && (cyc > md_start_cyc) && (cyc <= md_end_cyc);
        done = busy && (cyc == md_end_cyc);
        lu   = (s.mtr == 2'b01) && s.rw && (s.dst != 5'd0) &&
               ((s.rs_u && s.rs == s.dst) || (s.rt_u && s.rt == s.dst));
        hold = busy && (s.hilo || s.mdop);
        // {pc_wr_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}
        if (!s.rst)          o = 7'b0010101;
        else if (s.ms)       o = 7'b0000001;
        else if (lu || hold) o = 7'b0001110;
        else if (s.br)       o = 7'b1111010;
        else                 o = 7'b1101010;
        e.ctl = {o, busy, done};
        e.pm  = cnt_m;
        e.ph  = cnt_h;
        e.pf  = cnt_f;
        e.tag = tag;
        e.cyc = cyc;
        q.push_back(e);

        if (!s.rst) begin
            md_start_cyc = -1;
            md_end_cyc   = -1;
            cnt_m = 0;
            cnt_h = 0;
            cnt_f = 0;
        end else begin
            if (s.start && !s.ms && !busy) begin
                md_start_cyc = cyc;
                md_end_cyc   = cyc + (s.isdiv ? 33 : 4);
            end
            if (s.ms)            cnt_m++;
            else if (lu || hold) cnt_h++;
            else if (s.br)       cnt_f++;
        end
        cyc++;
    endtask

    initial begin : monitor
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {hz.pc_wr_en_o, hz.ifid_en_o, hz.ifid_flush_o, hz.idex_en_o,
                       hz.idex_bubble_o, hz.exmem_en_o, hz.memwb_bubble_o,
                       hz.md_busy_o, hz.md_done_o};
                total++;
                if (act !== e.ctl) begin
                    bad++;
                    $display("FAIL %s cyc=%0d ctl got=%b want=%b", e.tag, e.cyc, act, e.ctl);
                end
`ifdef PIPE_HAZARD_PERF_EN
                total++;
                if (perf_m !== e.pm || perf_h !== e.ph || perf_f !== e.pf) begin
                    bad++;
                    $display("FAIL %s_perf cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                             e.tag, e.cyc, perf_m, perf_h, perf_f, e.pm, e.ph, e.pf);
                end
`endif
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        stim_t lu_s;

        s = nop();
        s.rst = 1'b0;
        repeat (3) step(s, "reset");
        repeat (2) step(nop(), "idle");

        lu_s = nop();
        lu_s.mtr = 2'b01; lu_s.rw = 1'b1; lu_s.dst = 5'd8; lu_s.rs = 5'd8; lu_s.rs_u = 1'b1;
        step(lu_s, "load_use");
        s = lu_s; s.mtr = 2'b00;
        step(s, "load_use_release");
        s = lu_s; s.dst = 5'd0; s.rs = 5'd0;
        step(s, "load_use_r0");
        s = lu_s; s.rs_u = 1'b0; s.rt = 5'd8; s.rt_u = 1'b1;
        step(s, "load_use_rt");

        s = nop(); s.start = 1'b1;
        step(s, "mul_start");
        s = nop(); s.hilo = 1'b1;
        repeat (6) step(s, "mul_hold");

        s = nop(); s.start = 1'b1; s.isdiv = 1'b1;
        step(s, "div_start");
        s = nop(); s.ms = 1'b1;
        repeat (10) step(s, "div_memwait");
        s = nop(); s.hilo = 1'b1;
        repeat (25) step(s, "div_hold");

        s = lu_s; s.ms = 1'b1; s.br = 1'b1;
        step(s, "prio_p1");
        s = lu_s; s.br = 1'b1;
        step(s, "prio_p2");
        s = nop(); s.br = 1'b1;
        step(s, "prio_p3");

        s = nop(); s.start = 1'b1; s.isdiv = 1'b1;
        step(s, "rdiv_start");
        repeat (9) step(nop(), "rdiv_run");
        s = nop(); s.rst = 1'b0;
        repeat (2) step(s, "rdiv_reset");
        s = nop(); s.hilo = 1'b1;
        repeat (40) step(s, "rdiv_after");

        s = nop(); s.rst = 1'b0;
        step(s, "perf_reset");
        s = nop(); s.ms = 1'b1;
        repeat (3) step(s, "perf_mem");
        repeat (2) step(lu_s, "perf_lu");
        s = nop(); s.br = 1'b1;
        step(s, "perf_br");
        repeat (2) step(nop(), "perf_read");

        for (int i = 0; i < 3000; i++) begin
            s.rst   = ($urandom_range(199) != 0);
            s.rs    = 5'($urandom_range(3));
            s.rt    = 5'($urandom_range(3));
            s.dst   = 5'($urandom_range(3));
            s.rs_u  = 1'($urandom_range(1));
            s.rt_u  = 1'($urandom_range(1));
            s.mtr   = 2'($urandom_range(2));
            s.rw    = 1'($urandom_range(1));
            s.hilo  = ($urandom_range(3) == 0);
            s.mdop  = ($urandom_range(7) == 0);
            s.br    = ($urandom_range(3) == 0);
            s.start = ($urandom_range(9) == 0);
            s.isdiv = 1'($urandom_range(1));
            s.ms    = ($urandom_range(4) == 0);
            step(s, "random");
        end

        for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
